// File: rtl/rr_arb_mux.sv
// N-way round-robin arbitrated mux with one registered output stage and valid/ready handshakes.
// Optional packet locking (in_last port) is enabled by defining RR_ARB_MUX_LOCK_EN.
module rr_arb_mux #(
    parameter  int WIDTH = 32,
    parameter  int N     = 16,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [N-1:0]         in_last,
`endif
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] grant_next;
    logic             grant_vld;
    logic             load;
    logic [SEL_W:0]   idx_ext;
    logic [SEL_W-1:0] idx;

`ifdef RR_ARB_MUX_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_sel;
`endif

    assign load = !out_valid || out_ready;

    // Rotating priority search starting at rr_ptr; the modulo wrap handles non-power-of-two N.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx_ext   = '0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx_ext = {1'b0, rr_ptr} + (SEL_W+1)'(i);
            if (idx_ext >= (SEL_W+1)'(N)) begin
                idx_ext = idx_ext - (SEL_W+1)'(N);
            end
            idx = idx_ext[SEL_W-1:0];
            if (!grant_vld && in_valid[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
`ifdef RR_ARB_MUX_LOCK_EN
        // A packet in flight owns the bus; an idle owner stalls everyone else.
        if (locked) begin
            grant     = lock_sel;
            grant_vld = in_valid[lock_sel];
        end
`endif
    end

    assign grant_next = (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);

    always_comb begin
        in_ready = '0;
        if (rst_n && load && grant_vld) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
            locked    <= 1'b0;
            lock_sel  <= '0;
`endif
        end else if (load) begin
            if (grant_vld) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
                out_sel   <= grant;
`ifdef RR_ARB_MUX_LOCK_EN
                if (in_last[grant]) begin
                    locked <= 1'b0;
                    rr_ptr <= grant_next;
                end else begin
                    locked   <= 1'b1;
                    lock_sel <= grant;
                end
`else
                rr_ptr    <= grant_next;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-way, WIDTH-bit registered mux, successor to the fixed 16:1 combinational select.
- Selection comes from an internal round-robin arbiter over per-channel valid/ready handshakes, not an external sel.
- One output register stage, one beat per cycle.
- Used to merge request streams (e.g. I/D-side memory requests, writeback sources) onto one shared consumer.

Parameters:
- WIDTH, 32, data bits per channel
- N, 16, number of input channels (2..64, any value, not limited to powers of two)
- SEL_W, $clog2(N), width of channel index (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  N  per-channel request valid
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_ready  output  N  per-channel accept (combinational)
- out_valid  output  1  registered output valid
- out_data  output  WIDTH  registered output data
- out_sel  output  SEL_W  index of the channel that produced out_data
- out_ready  input  1  downstream accept

Behaviour:
- Reset (rst_n=0 sampled at posedge): out_valid=0, out_data=0, out_sel=0, rr_ptr=0, in_ready=0 during reset. Reset mid-transfer discards the held beat; no input is accepted in the reset cycle.
- load = !out_valid || out_ready. Output register loads when load=1.
- Grant: g = first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1. Wrap is at N-1 to 0 for non-power-of-two N.
- in_ready[k] = load && any(in_valid) && (k==g). At most one in_ready is high. in_ready never depends on in_ready or on out_ready of the same channel through a loop.
- On handshake (in_valid[g] && in_ready[g]) at posedge:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - rr_ptr <= (g==N-1) ? 0 : g+1
- If load=1 and no in_valid: out_valid <= 0. out_data and out_sel hold their last values. rr_ptr unchanged.
- If load=0 (out_valid=1, out_ready=0): out_* hold and all in_ready=0.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 beat/cycle when out_ready held high.
- Fairness: with all N channels continuously valid, each is granted exactly once per N consecutive grants.
- Inputs are assumed AXI-style: a valid beat is not withdrawn before it is accepted. The block does not check this.

Optional Feature:
- Macro: RR_ARB_MUX_LOCK_EN
- Defined:
  - Adds port in_last  input  N, marking the last beat of a packet.
  - Adds internal state: locked, lock_sel.
  - When a beat is accepted from g with in_last[g]=0: locked <= 1, lock_sel <= g.
  - While locked, the grant is forced to lock_sel. Other channels get in_ready=0 even if lock_sel is not valid; the bus stalls rather than interleaving packets.
  - Accepting a beat with in_last=1 clears locked and advances rr_ptr as normal.
  - rr_ptr does not advance on non-last beats.
  - Reset clears locked to 0.
- Not defined: in_last port and lock state are absent. Every beat is arbitrated independently.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=all-ones -> out_valid=0, out_sel=0, in_ready=0. First grant after release goes to channel 0.
- Single channel: N=16, only in_valid[5]=1, in_data[5]=32'hDEADBEEF, out_ready=1 -> in_ready[5]=1 in the same cycle. Next cycle out_valid=1, out_data=32'hDEADBEEF, out_sel=5.
- Round-robin wrap: N=5 (non-power-of-two), all valid, out_ready=1 -> out_sel sequence 0,1,2,3,4,0,1. Each grant is one cycle.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_sel stable and in_ready=0 throughout. Raise out_ready -> the next grant loads the same cycle; no beat lost or duplicated.
- Skip/idle: rr_ptr=3, in_valid only on channels 1 and 9 -> grant 9 then 1. After drain with no valid, out_valid drops to 0.
- Lock (RR_ARB_MUX_LOCK_EN): channel 2 sends 3 beats with in_last=0,0,1 while channel 3 is valid throughout -> out_sel=2,2,2,3. Channel 3 sees in_ready=0 until channel 2's last beat is accepted.
